opseq_gen: RTL

Programmable operand-sequence generator that sits directly upstream of the `mlopadd` accumulator and produces its 8-bit `x` stream. After a `start` pulse it emits an arithmetic progression of `len` terms (`first`, `first+step`, …) over a valid/ready handshake, one term per cycle when not stalled. Power-on settings `first=1`, `step=2`, `len=100` produce the odd-number stream whose running sum is 10000.

---
 rtl/opseq_pkg.sv | 7 +
 rtl/rgst.sv | 15 +
 rtl/opseq_gen.sv | 50 +++++
 3 files changed

// File: rtl/opseq_pkg.sv
// opseq_pkg: shared state encoding and power-on defaults for the operand-sequence generator
package opseq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} opseq_state_t;
  localparam int OPSEQ_FIRST = 1;
  localparam int OPSEQ_STEP  = 2;
  localparam int OPSEQ_LEN   = 100;
endpackage

// File: rtl/rgst.sv
// rgst: loadable register with synchronous reset to a parameterised value
module rgst #(
  parameter int W = 8,
  parameter logic [W-1:0] RV = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= RV;
    else if (ld) q <= d;
endmodule

// File: rtl/opseq_gen.sv
// opseq_gen: emits an arithmetic progression of len terms over a valid/ready handshake
module opseq_gen
  import opseq_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  first,
  input  logic [W-1:0]  step,
  input  logic [CW-1:0] len,
  output logic [W-1:0]  x,
  output logic          x_vld,
  input  logic          x_rdy,
  output logic          busy,
  output logic          done
);
  opseq_state_t state, nxt;
  logic [W-1:0] step_q;
  logic [CW-1:0] len_q, cnt;
  logic go, hs, last;
  assign go   = state == IDLE && start;
  assign hs   = state == RUN && x_rdy;
  assign last = cnt == len_q - CW'(1);
  rgst #(.W(W), .RV(W'(OPSEQ_STEP))) u_step (
    .clk(clk), .rst(rst), .ld(go), .d(step), .q(step_q)
  );
  rgst #(.W(CW), .RV(CW'(OPSEQ_LEN))) u_len (
    .clk(clk), .rst(rst), .ld(go), .d(len), .q(len_q)
  );
  // go and hs are mutually exclusive, so one load enable serves both sources
  rgst #(.W(W)) u_x (
    .clk(clk), .rst(rst), .ld(go | hs), .d(go ? first : x + step_q), .q(x)
  );
  rgst #(.W(CW)) u_cnt (
    .clk(clk), .rst(rst), .ld(go | hs), .d(go ? '0 : cnt + CW'(1)), .q(cnt)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE ? (start ? (len == '0 ? DONE : RUN) : IDLE) :
          state == RUN  ? (hs && last ? DONE : RUN) : IDLE;
  end
  assign x_vld = state == RUN;
  assign busy  = state != IDLE;
  assign done  = state == DONE;
endmodule
